// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: PC ownership, bounded in-order instruction queue,
// and NOP bubbles for stall/redirect toward enable-less pipeline registers.
module rv32i_fetch #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] instF,
    output logic [WIDTH-1:0] pcF,
    output logic             validF
);
    localparam int unsigned      PW   = $clog2(DEPTH);
    localparam int unsigned      CW   = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    discard_q, discard_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];

    logic             accept, resp_fire, push, pop;
    logic [CW:0]      occupancy;
    logic [WIDTH-1:0] redirect_base;

    // In-flight words reserve a queue slot, so a push can never hit a full queue.
    assign occupancy     = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req      = !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr     = req_pc_q;
    assign accept        = imem_req && imem_ready;
    assign resp_fire     = imem_rvalid && (outstanding_q != '0);
    assign push          = resp_fire && (discard_q == '0) && !redirect;
    assign validF        = (count_q != '0) && !stall && !redirect;
    assign pop           = validF;
    assign instF         = validF ? inst_mem[rd_ptr_q] : NOP;
    assign pcF           = validF ? pc_mem[rd_ptr_q] : '0;
    assign redirect_base = redirect_pc & ~WIDTH'(3);

    always_comb begin
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp_fire);
        discard_d     = discard_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) req_pc_d = req_pc_q + STEP;
        if (resp_fire && (discard_q != '0)) discard_d = discard_q - CW'(1);
        if (push) begin
            resp_pc_d = resp_pc_q + STEP;
            wr_ptr_d  = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        // Every word still in flight after this cycle's response is stale.
        if (redirect) begin
            req_pc_d  = redirect_base;
            resp_pc_d = redirect_base;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            discard_d = outstanding_q - CW'(resp_fire);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: a word=address memory model with selectable latency
// plus manually driven responses for the redirect and reset corner cases.
module tb_rv32i_fetch;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [WIDTH-1:0]  imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [WIDTH-1:0]  imem_rdata;
    logic              stall;
    logic              redirect;
    logic [WIDTH-1:0]  redirect_pc;
    logic [WIDTH-1:0]  instF;
    logic [WIDTH-1:0]  pcF;
    logic              validF;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned acc_cnt = 0;
    int unsigned pop_cnt = 0;

    always #5 clk = ~clk;

    rv32i_fetch #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000),
        .NOP(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instF(instF),
        .pcF(pcF),
        .validF(validF)
    );

    // Memory responder: word = address, returned lat cycles after accept.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t        pend[$];
    bit          auto_mem;
    int unsigned lat;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        man_rvalid;
    logic [31:0] man_rdata;

    assign imem_rvalid = auto_mem ? mem_rvalid : man_rvalid;
    assign imem_rdata  = auto_mem ? mem_rdata  : man_rdata;

    initial begin
        int unsigned cyc;
        logic        acc_s;
        logic [31:0] addr_s;
        cyc        = 0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            acc_s  = imem_req && imem_ready && !reset;
            addr_s = imem_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (acc_s && auto_mem) pend.push_back('{addr_s, cyc - 1 + lat});
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (auto_mem && pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].addr;
                void'(pend.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Book-keep this cycle's accept/pop, then move to just after the next rising edge.
    task automatic cyc_go();
        if (!reset && imem_req && imem_ready) acc_cnt++;
        if (!reset && validF) pop_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int unsigned occ;
        int unsigned n_out;

        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        auto_mem    = 1'b1;
        lat         = 1;
        man_rvalid  = 1'b0;
        man_rdata   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_validF", {31'b0, validF}, 32'd0);
        chk("rst_instF", instF, NOP);
        chk("rst_pcF", pcF, 32'd0);

        // Cycle 0: first cycle after reset release.
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("c0_req", {31'b0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'd0);
        chk("c0_validF", {31'b0, validF}, 32'd0);
        chk("c0_instF", instF, NOP);
        cyc_go();
        @(negedge clk);
        chk("c1_validF", {31'b0, validF}, 32'd0);
        chk("c1_addr", imem_addr, 32'd4);
        for (int k = 2; k <= 7; k++) begin
            cyc_go();
            @(negedge clk);
            chk("stream_validF", {31'b0, validF}, 32'd1);
            chk("stream_instF", instF, 32'(4 * (k - 2)));
            chk("stream_pcF", pcF, 32'(4 * (k - 2)));
            chk("stream_addr", imem_addr, 32'(4 * k));
        end

        // Stall for cycles 8..10; queue fills to the 4-entry cap.
        for (int k = 8; k <= 10; k++) begin
            cyc_go();
            stall = 1'b1;
            @(negedge clk);
            chk("stall_validF", {31'b0, validF}, 32'd0);
            chk("stall_instF", instF, NOP);
            chk("stall_pcF", pcF, 32'd0);
            if (k == 10) chk("stall_req_cap", {31'b0, imem_req}, 32'd0);
        end
        cyc_go();
        stall = 1'b0;
        @(negedge clk);
        chk("resume_req_cap", {31'b0, imem_req}, 32'd0);
        chk("resume_validF", {31'b0, validF}, 32'd1);
        chk("resume_instF", instF, 32'd24);
        chk("resume_pcF", pcF, 32'd24);
        for (int k = 12; k <= 16; k++) begin
            cyc_go();
            @(negedge clk);
            chk("resume_seq_validF", {31'b0, validF}, 32'd1);
            chk("resume_seq_instF", instF, 32'(24 + 4 * (k - 11)));
            if (k == 12) chk("resume_addr", imem_addr, 32'd40);
        end

        // Three-cycle memory latency: capacity bound and in-order output.
        exp_pc = 32'd48;
        n_out  = 0;
        for (int k = 0; k < 40; k++) begin
            cyc_go();
            if (k == 0) lat = 3;
            @(negedge clk);
            occ = acc_cnt - pop_cnt;
            chk("lat3_cap", 32'((occ + ((imem_req && imem_ready) ? 1 : 0)) <= DEPTH), 32'd1);
            if (validF) begin
                chk("lat3_instF", instF, exp_pc);
                chk("lat3_pcF", pcF, exp_pc);
                exp_pc = exp_pc + 32'd4;
                n_out++;
            end
        end
        chk("lat3_progress", 32'(n_out >= 20), 32'd1);

        // Drain, then redirect with two words in flight.
        cyc_go();
        imem_ready = 1'b0;
        for (int k = 0; k < 10; k++) cyc_go();
        @(negedge clk);
        chk("drain_empty", {31'b0, validF}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc_go();
            imem_ready = 1'b1;
            @(negedge clk);
            chk("pre_redir_req", {31'b0, imem_req}, 32'd1);
        end
        cyc_go();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("redir_req_low", {31'b0, imem_req}, 32'd0);
        chk("redir_validF", {31'b0, validF}, 32'd0);
        cyc_go();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_new_addr", imem_addr, 32'h0000_0100);
        chk("redir_new_req", {31'b0, imem_req}, 32'd1);
        chk("redir_drop0", {31'b0, validF}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc_go();
            @(negedge clk);
            chk("redir_drop", {31'b0, validF}, 32'd0);
        end
        cyc_go();
        @(negedge clk);
        chk("redir_first_validF", {31'b0, validF}, 32'd1);
        chk("redir_first_pcF", pcF, 32'h0000_0100);
        chk("redir_first_instF", instF, 32'h0000_0100);
        cyc_go();
        @(negedge clk);
        chk("redir_second_pcF", pcF, 32'h0000_0104);

        // Redirect together with a response and a stall (manual responses).
        cyc_go();
        imem_ready = 1'b0;
        for (int k = 0; k < 10; k++) cyc_go();
        auto_mem = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc_go();
            imem_ready = 1'b1;
            @(negedge clk);
            chk("m_accept_req", {31'b0, imem_req}, 32'd1);
        end
        cyc_go();
        imem_ready = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hAAAA_0001;
        @(negedge clk);
        chk("m_push_validF", {31'b0, validF}, 32'd0);
        cyc_go();
        man_rdata   = 32'hBBBB_0002;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h2000_000A;
        @(negedge clk);
        chk("srr_validF", {31'b0, validF}, 32'd0);
        chk("srr_instF", instF, NOP);
        chk("srr_pcF", pcF, 32'd0);
        chk("srr_req", {31'b0, imem_req}, 32'd0);
        cyc_go();
        man_rvalid = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("srr_empty", {31'b0, validF}, 32'd0);
        chk("srr_addr", imem_addr, 32'h2000_0008);
        chk("srr_req_again", {31'b0, imem_req}, 32'd1);
        cyc_go();
        imem_ready = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hCCCC_0003;
        @(negedge clk);
        chk("srr_wait_validF", {31'b0, validF}, 32'd0);
        cyc_go();
        man_rvalid = 1'b0;
        @(negedge clk);
        chk("srr_next_validF", {31'b0, validF}, 32'd1);
        chk("srr_next_instF", instF, 32'hCCCC_0003);
        chk("srr_next_pcF", pcF, 32'h2000_0008);

        // Reset with three words outstanding; stale responses afterwards are ignored.
        for (int k = 0; k < 3; k++) begin
            cyc_go();
            imem_ready = 1'b1;
            @(negedge clk);
            chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            cyc_go();
            imem_ready = 1'b0;
            reset      = 1'b1;
            @(negedge clk);
            chk("mid_rst_validF", {31'b0, validF}, 32'd0);
            chk("mid_rst_instF", instF, NOP);
            chk("mid_rst_pcF", pcF, 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc_go();
            reset      = 1'b0;
            man_rvalid = 1'b1;
            man_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("stale_validF", {31'b0, validF}, 32'd0);
            chk("stale_addr", imem_addr, 32'd0);
            chk("stale_req", {31'b0, imem_req}, 32'd1);
        end
        cyc_go();
        man_rvalid = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_validF", {31'b0, validF}, 32'd0);
        chk("post_rst_addr", imem_addr, 32'd0);
        cyc_go();
        imem_ready = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'h0000_0077;
        @(negedge clk);
        chk("post_rst_addr_next", imem_addr, 32'd4);
        chk("post_rst_wait", {31'b0, validF}, 32'd0);
        cyc_go();
        man_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_first_validF", {31'b0, validF}, 32'd1);
        chk("post_rst_first_instF", instF, 32'h0000_0077);
        chk("post_rst_first_pcF", pcF, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32i_fetch.md
# rv32i_fetch

Instruction fetch stage for the RV32I core. Owns the program counter, issues word requests to instruction memory, buffers returned words in a small in-order queue and presents one instruction per cycle on `instF` to the fetch/decode/compute/writeback pipeline registers. Downstream registers capture every cycle and have no enable, so a stall or flush is expressed by driving a NOP bubble. Branch/jump redirects from the compute stage flush the queue and discard in-flight responses.

## Interface
- `WIDTH`, 32: instruction and address width.
- `DEPTH`, 4: instruction queue entries (power of two, ≥2); also the cap on outstanding + queued words.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `imem_req`  out  1: request valid.
- `imem_addr`  out  WIDTH: word address of request; bits [1:0] always 0.
- `imem_ready`  in  1: memory accepts request this cycle (`imem_req && imem_ready` = accept).
- `imem_rvalid`  in  1: response valid; responses return in request order, ≥1 cycle after accept.
- `imem_rdata`  in  WIDTH: response word.
- `stall`  in  1: downstream hold; head not consumed, NOP driven.
- `redirect`  in  1: taken branch/jump; flush and refetch.
- `redirect_pc`  in  WIDTH: new fetch address; bits [1:0] ignored (treated as 0).
- `instF`  out  WIDTH: instruction to pipeline; NOP when `validF`=0.
- `pcF`  out  WIDTH: PC of `instF`; 0 when `validF`=0.
- `validF`  out  1: `instF` is a real instruction.

## Operation
- State: `req_pc`, `resp_pc` (PC of next accepted response), `outstanding` (0..DEPTH), `discard` (0..DEPTH), queue of {inst, pc} with `count` (0..DEPTH), read/write pointers wrapping modulo DEPTH.
- Issue: `imem_req` = !redirect && (outstanding + count < DEPTH); `imem_addr` = `req_pc`. On accept, `req_pc` += 4 (wraps mod 2^WIDTH), `outstanding` += 1.
- Response: each `imem_rvalid` decrements `outstanding`. If `discard` > 0 → dropped, `discard` -= 1. Else pushed as {`imem_rdata`, `resp_pc`}, `resp_pc` += 4. `imem_rvalid` with `outstanding`=0 is ignored.
- Output (combinational from registered queue): `validF` = (count>0) && !stall && !redirect; `instF`/`pcF` = head when `validF`, else NOP/0. Pop when `validF`.
- Simultaneous push and pop in one cycle: count unchanged; capacity rule guarantees no push into a full queue.
- Redirect (priority over stall and pop): queue cleared (count=0, pointers reset), no request issued that cycle, `req_pc` = `resp_pc` = {redirect_pc[WIDTH-1:2],2'b00}, `discard` = `outstanding` after this cycle's response is accounted (a same-cycle response is itself dropped, since all in-flight words are stale). Back-to-back redirects: each recomputes `discard` the same way.
- Reset (any time, including mid-burst): `req_pc`=`resp_pc`=RESET_PC, outstanding=discard=count=0, `imem_req`=1 from first cycle after reset deasserts (capacity permitting), `validF`=0, `instF`=NOP, `pcF`=0.

## Timing
- Zero-wait memory (ready=1, rvalid one cycle after accept): accept at cycle N, push at edge N+1, `instF` valid in cycle N+1 after edge... i.e. first instruction visible 2 cycles after reset release; then one instruction per cycle sustained with DEPTH≥2.
- Redirect at cycle R: new request at R+1, earliest valid `instF` from new PC at R+3 with zero-wait memory.
- No combinational path from `imem_rdata`/`imem_rvalid` to `instF`/`validF`; `stall` and `redirect` do reach `validF`/`instF` combinationally.
- `imem_req` depends combinationally only on `redirect` and registered state, never on `imem_ready`.

## Test plan
- Reset release, zero-wait memory returning word = address: `imem_addr` 0,4,8…; `instF`=0,4,8… with `pcF` equal, `validF`=1 every cycle from cycle 2.
- `stall` held 3 cycles mid-stream: `instF`=32'h13, `validF`=0 for 3 cycles; sequence resumes without loss or duplication; `imem_req` drops when outstanding+count=4.
- Memory latency 3 cycles, ready=1: never more than 4 outstanding+queued; output in order, no gaps once queue primed.
- `redirect` with `redirect_pc`=32'h0000_0103 while 2 words in flight: both responses dropped; next `imem_addr`=32'h100; first valid `pcF`=32'h100.
- Redirect in same cycle as `imem_rvalid` and `stall`: response dropped, `validF`=0, no pop, queue empty next cycle.
- Assert `reset` with 3 outstanding, then release: stale `imem_rvalid` pulses ignored; fetch restarts at RESET_PC.
